// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM type, majority voter and parameter legality rules for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_t;

    localparam int MIN_CLK_DIV    = 2;
    localparam int MIN_OVERSAMPLE = 4;
    localparam int MIN_DATA_BITS  = 5;
    localparam int MAX_DATA_BITS  = 9;
    localparam int MIN_FIFO_DEPTH = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic params_legal(input int clk_div, input int oversample,
                                          input int data_bits, input int fifo_depth);
        return clk_div >= MIN_CLK_DIV && oversample >= MIN_OVERSAMPLE && oversample % 2 == 0 &&
               data_bits >= MIN_DATA_BITS && data_bits <= MAX_DATA_BITS &&
               fifo_depth >= MIN_FIFO_DEPTH && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO with occupancy count and drop-on-full overrun pulse
module uart_rx_fifo
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ready,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop, full, do_push;

    assign valid   = count != '0;
    assign full    = count == (AW + 1)'(DEPTH);
    assign pop     = valid & ready;
    assign do_push = push & (~full | pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    // storage array, written only on accepted pushes
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    // pointers, occupancy and overrun pulse; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(do_push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count + (AW + 1)'(do_push) - (AW + 1)'(pop);
            overrun <= push & ~do_push;
        end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority voting, parity/framing checks and output FIFO
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 13,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int LSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LO     = BW'(M - 1);
    localparam logic [BW-1:0] B_MID    = BW'(M);
    localparam logic [BW-1:0] B_HI     = BW'(M + 1);
    localparam logic [BW-1:0] B_LAST   = BW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(DATA_BITS);

    if (!params_legal(CLK_DIV, OVERSAMPLE, DATA_BITS, FIFO_DEPTH)) begin : g_bad_params
        $error("uart_rx_core: illegal parameter combination");
    end

    rx_state_t              state, state_n;
    logic                   rx_m, rx_s, tick;
    logic [CW-1:0]          div_cnt;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [NW-1:0]          n_cnt, n_n;
    logic [DATA_BITS-1:0]   shreg, sh_n;
    logic                   s0, s0_n, s1, s1_n, perr_q, perr_n;
    logic                   vote, decide, bit_wrap, push, ferr;
    logic [DATA_BITS+1:0]   push_word, head_word;

    assign tick     = div_cnt == DIV_LAST;
    assign vote     = maj3(s0, s1, rx_s);
    assign decide   = bit_cnt == B_HI;
    assign bit_wrap = bit_cnt == B_LAST;

    // two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_s, rx_m} <= 2'b11;
        else     {rx_s, rx_m} <= {rx_m, rx};

    // free-running oversample tick divider, independent of frame activity
    always_ff @(posedge clk or posedge rst)
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;

    // framing FSM and datapath registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            n_cnt   <= '0;
            shreg   <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            n_cnt   <= n_n;
            shreg   <= sh_n;
            s0      <= s0_n;
            s1      <= s1_n;
            perr_q  <= perr_n;
        end

    // next-state logic: everything advances only on ticks; decisions are taken at sample M+1
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        n_n     = n_cnt;
        sh_n    = shreg;
        s0_n    = s0;
        s1_n    = s1;
        perr_n  = perr_q;
        push    = 1'b0;
        ferr    = 1'b0;
        if (tick) begin
            bit_n = bit_wrap ? '0 : bit_cnt + 1'b1;
            s0_n  = bit_cnt == B_LO ? rx_s : s0;
            s1_n  = bit_cnt == B_MID ? rx_s : s1;
            case (state)
                IDLE: begin
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : START;
                end
                START: state_n = (decide && vote) ? IDLE : (bit_wrap ? DATA : START);
                DATA: begin
                    if (decide) begin
                        sh_n = (LSB_FIRST != 0) ? {vote, shreg[DATA_BITS-1:1]} : {shreg[DATA_BITS-2:0], vote};
                        n_n  = n_cnt + 1'b1;
                    end
                    if (bit_wrap && n_cnt == N_LAST) begin
                        n_n     = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) perr_n = ^shreg ^ vote ^ (PARITY_ODD != 0);
                    if (bit_wrap) state_n = STOP;
                end
                STOP: if (decide) begin
                    push    = 1'b1;
                    ferr    = ~vote;
                    state_n = vote ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end

    assign push_word = {ferr, (PARITY_EN != 0) & perr_q, shreg};

    uart_rx_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (push_word),
        .ready   (rx_ready),
        .rdata   (head_word),
        .valid   (rx_valid),
        .overrun (overrun),
        .count   (fifo_level)
    );

    assign rx_data = head_word[DATA_BITS-1:0];
    assign rx_perr = head_word[DATA_BITS];
    assign rx_ferr = head_word[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized scoreboard bench for the UART receiver (8E1, fast divider)
module tb_uart_rx_core;
    localparam int CLK_DIV    = 4;
    localparam int OVERSAMPLE = 8;
    localparam int DATA_BITS  = 8;
    localparam int PARITY_EN  = 1;
    localparam int PARITY_ODD = 0;
    localparam int LSB_FIRST  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT        = CLK_DIV * OVERSAMPLE;

    logic                        clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
    logic [DATA_BITS-1:0]        rx_data;
    logic                        rx_perr, rx_ferr, rx_valid, overrun;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    logic [DATA_BITS+1:0] exp_q[$];
    logic [DATA_BITS+1:0] mon_e;
    int checks = 0, errors = 0, ov_seen = 0, ov_exp = 0, ready_mode = 0;

    uart_rx_core #(
        .CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(DATA_BITS), .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD), .LSB_FIRST(LSB_FIRST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: even/odd parity over data plus parity bit, framing error when stop bit is low
    function automatic logic [DATA_BITS+1:0] model(input logic [DATA_BITS-1:0] d, input logic p, input logic stop_low);
        logic perr;
        perr = (PARITY_EN != 0) && ((($countones(d) + int'(p)) % 2) != PARITY_ODD);
        return {stop_low, perr, d};
    endfunction

    function automatic logic good_parity(input logic [DATA_BITS-1:0] d);
        return (($countones(d) + PARITY_ODD) % 2) == 1;
    endfunction

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic p, input int stop_low_bits);
        rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = (LSB_FIRST != 0) ? d[i] : d[DATA_BITS-1-i];
            wait_cyc(BIT);
        end
        if (PARITY_EN != 0) begin
            rx = p;
            wait_cyc(BIT);
        end
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            wait_cyc(stop_low_bits * BIT);
        end
        rx = 1'b1;
        wait_cyc(BIT);
    endtask

    task automatic send_exp(input logic [DATA_BITS-1:0] d, input logic p, input int stop_low_bits);
        exp_q.push_back(model(d, p, stop_low_bits > 0));
        send_frame(d, p, stop_low_bits);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30 * BIT) begin
            wait_cyc(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // consumer ready generator
    initial forever begin
        @(posedge clk);
        #1;
        rx_ready = ready_mode == 2 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    // monitor: every accepted head word is compared against the oldest expected word
    initial forever begin
        @(negedge clk);
        if (overrun) ov_seen++;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data=%0h perr=%0b ferr=%0b, expected no word", rx_data, rx_perr, rx_ferr);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", int'(rx_data), int'(mon_e[DATA_BITS-1:0]));
                check("word_perr", int'(rx_perr), int'(mon_e[DATA_BITS]));
                check("word_ferr", int'(rx_ferr), int'(mon_e[DATA_BITS+1]));
            end
        end
    end

    initial begin
        logic [DATA_BITS-1:0] d;
        wait_cyc(3);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_perr", int'(rx_perr), 0);
        check("rst_rx_ferr", int'(rx_ferr), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        rst = 1'b0;
        wait_cyc(2 * BIT);
        ready_mode = 2;
        send_exp(8'hA5, good_parity(8'hA5), 0);
        drain("drain_a5");
        // short low glitch on idle line must be rejected
        rx = 1'b0;
        wait_cyc(2 * CLK_DIV);
        rx = 1'b1;
        wait_cyc(3 * BIT);
        check("glitch_fifo_level", int'(fifo_level), 0);
        check("glitch_rx_valid", int'(rx_valid), 0);
        send_exp(8'h07, 1'b0, 0);
        send_exp(8'h07, 1'b1, 0);
        drain("drain_parity");
        // break: stop bit held low for three bit periods yields exactly one word
        send_exp(8'h55, good_parity(8'h55), 3);
        wait_cyc(2 * BIT);
        send_exp(8'h3A, good_parity(8'h3A), 0);
        drain("drain_break");
        // randomized traffic with random consumer back-pressure and random parity faults
        ready_mode = 1;
        for (int k = 0; k < 30; k++) begin
            d = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
            send_exp(d, ($urandom_range(0, 3) == 0) ? ~good_parity(d) : good_parity(d), 0);
            wait_cyc($urandom_range(1, 40));
        end
        ready_mode = 2;
        drain("drain_random");
        // overrun: five words into a four-deep FIFO with consumer stalled
        ready_mode = 0;
        wait_cyc(4);
        for (int k = 1; k <= 5; k++) begin
            d = DATA_BITS'(k);
            if (k <= FIFO_DEPTH) exp_q.push_back(model(d, good_parity(d), 1'b0));
            send_frame(d, good_parity(d), 0);
            wait_cyc($urandom_range(1, BIT));
        end
        ov_exp++;
        check("ovr_fifo_level", int'(fifo_level), FIFO_DEPTH);
        check("ovr_pulses", ov_seen, ov_exp);
        check("ovr_head_data", int'(rx_data), 1);
        ready_mode = 2;
        drain("drain_overrun");
        wait_cyc(2);
        check("ovr_level_empty", int'(fifo_level), 0);
        // reset mid-frame empties the FIFO and discards the partial frame
        ready_mode = 0;
        wait_cyc(4);
        d = 8'h99;
        send_frame(d, good_parity(d), 0);
        check("pre_rst_level", int'(fifo_level), 1);
        d = 8'h3C;
        rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_cyc(BIT);
        end
        rst = 1'b1;
        #1;
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_valid", int'(rx_valid), 0);
        check("midrst_data", int'(rx_data), 0);
        rx = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        ready_mode = 2;
        wait_cyc(BIT);
        send_exp(8'hC3, good_parity(8'hC3), 0);
        drain("drain_after_rst");
        wait_cyc(2 * BIT);
        check("final_overruns", ov_seen, ov_exp);
        check("final_level", int'(fifo_level), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
